// File: rtl/instr_resp_if.sv
// Request/response bundle between the PC stage, instr_resp and the decode stage.
//
// Signals:
//   req_valid    PC stage has a fetch request
//   req_addr     byte address of the requested instruction
//   req_ready    instr_resp accepts the request this cycle
//   rsp_valid    response FIFO head is valid
//   rsp_ready    consumer takes the head this cycle
//   rsp_instr    head instruction
//   rsp_addr     head byte address
//   rsp_misalign head request had a non-word-aligned address
//
// Modports:
//   master  upstream/downstream side (drives requests, accepts responses)
//   slave   instr_resp side
interface instr_resp_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_misalign;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_instr,
    input  rsp_addr,
    input  rsp_misalign
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    input  rsp_ready,
    output rsp_instr,
    output rsp_addr,
    output rsp_misalign
  );
endinterface

// File: rtl/instr_resp.sv
// Instruction fetch response buffer.
//
// Accepts fetch requests, issues single-cycle-latency reads to instruction memory, and
// queues the returned instructions (with their byte address) in a 2-entry in-order FIFO.
// A request accepted in cycle N is visible at the FIFO head in cycle N+2. A flush drops
// everything pending, including the read data returning in the flush cycle.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   flush      redirect: discard all pending fetches
//   bus        instr_resp_if.slave (request and response handshakes)
//   mem_en     instruction memory read strobe
//   mem_addr   word address (req_addr[31:2]); don't-care when mem_en = 0
//   mem_rdata  read data, valid the cycle after mem_en
//
// Configuration:
//   INSTR_RESP_MISALIGN_CHK_EN  when defined, requests with req_addr[1:0] != 0 skip the
//                               memory read and respond with NOP_INSTR and rsp_misalign = 1.
//                               When undefined, every request is treated as aligned.
module instr_resp #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned BUF_DEPTH = 2  // fixed: pointers are 1 bit wide
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  instr_resp_if.slave        bus,
  output logic               mem_en,
  output logic [29:0]        mem_addr,
  input  logic [31:0]        mem_rdata
);

  localparam logic [1:0] FullCount = BUF_DEPTH[1:0];

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        misalign;
  } entry_t;

  // FIFO state
  entry_t     fifo_q [BUF_DEPTH];
  entry_t     fifo_d [BUF_DEPTH];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;

  // In-flight register: request whose memory read returns this cycle
  logic        infl_valid_q, infl_valid_d;
  logic [31:0] infl_addr_q, infl_addr_d;
  logic        infl_mis_q, infl_mis_d;

  logic       aligned;
  logic       rsp_valid;
  logic       pop;
  logic       accept;
  logic       push;
  logic       pop_fifo;
  logic [2:0] occupancy;
  entry_t     new_entry;
  entry_t     head;

`ifdef INSTR_RESP_MISALIGN_CHK_EN
  assign aligned = (bus.req_addr[1:0] == 2'b00);
`else
  assign aligned = 1'b1;
`endif

  // Handshake and datapath control
  always_comb begin
    rsp_valid = !rst && (count_q != 2'd0);
    pop       = rsp_valid && bus.rsp_ready;
    // Slots already committed (queued + in flight), minus the one leaving this cycle.
    // pop only happens with count_q >= 1, so this never underflows.
    occupancy = {1'b0, count_q} + {2'b00, infl_valid_q} - {2'b00, pop};
    bus.req_ready = !rst && !flush && (occupancy < 3'd2);
    accept    = bus.req_valid && bus.req_ready;
    mem_en    = accept && aligned;
    mem_addr  = bus.req_addr[31:2];
    // Flush kills both the returning read and any pop in the same cycle.
    push      = infl_valid_q && !flush;
    pop_fifo  = pop && !flush;
  end

  // Entry built from the read that returns this cycle
  always_comb begin
    new_entry.instr    = infl_mis_q ? NOP_INSTR : mem_rdata;
    new_entry.addr     = infl_addr_q;
    new_entry.misalign = infl_mis_q;
  end

  // Next-state
  always_comb begin
    fifo_d   = fifo_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    infl_valid_d = accept;
    infl_addr_d  = accept ? bus.req_addr : 32'h0;
    infl_mis_d   = accept && !aligned;

    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = new_entry;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop_fifo) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      infl_valid_q <= 1'b0;
      infl_addr_q  <= 32'h0;
      infl_mis_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      infl_valid_q <= infl_valid_d;
      infl_addr_q  <= infl_addr_d;
      infl_mis_q   <= infl_mis_d;
    end
  end

  // Storage needs no reset: it is only read while count_q says it holds data.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // Response outputs, forced to idle values when the head is not valid
  always_comb begin
    head             = fifo_q[rd_ptr_q];
    bus.rsp_valid    = rsp_valid;
    bus.rsp_instr    = NOP_INSTR;
    bus.rsp_addr     = 32'h0;
    bus.rsp_misalign = 1'b0;
    if (rsp_valid) begin
      bus.rsp_instr    = head.instr;
      bus.rsp_addr     = head.addr;
      bus.rsp_misalign = head.misalign;
    end
  end

  // The req_ready occupancy rule must make a push into a full FIFO impossible
  // unless the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_fifo && (count_q == FullCount)));

endmodule

// File: tb/tb_instr_resp.sv
// Randomized + directed bench for instr_resp against a timestamped response-queue model.
module tb_instr_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_en;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  instr_resp_if bus ();

  instr_resp dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  localparam logic [31:0] Nop = 32'h0000_0013;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected response: becomes visible at the FIFO head from cycle 'due' onwards
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        mis;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  logic        prev_fetch = 1'b0;
  logic [29:0] prev_waddr = '0;
  logic [31:0] dmem [64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    if (w < 30'd64) return dmem[w[5:0]];
    return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit is_aligned(input logic [31:0] a);
`ifdef INSTR_RESP_MISALIGN_CHK_EN
    return a[1:0] == 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model after the edge.
  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] a,
                      input logic rr);
    int   fifo_n;
    int   infl_n;
    logic exp_valid, exp_pop, exp_ready, exp_accept, exp_en;
    exp_t hd;
    exp_t ne;

    rst           = r;
    flush         = f;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.rsp_ready = rr;
    mem_rdata     = prev_fetch ? mem_word(prev_waddr) : $urandom();

    fifo_n = 0;
    infl_n = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i].due <= cyc) fifo_n++;
      else if (exp_q[i].due == cyc + 1) infl_n++;
    end
    exp_valid  = !r && (fifo_n > 0);
    exp_pop    = exp_valid && rr;
    exp_ready  = !r && !f && ((fifo_n + infl_n - int'(exp_pop)) < 2);
    exp_accept = v && exp_ready;
    exp_en     = exp_accept && is_aligned(a);

    @(negedge clk);
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      hd = exp_q[0];
      check_eq("rsp_instr", bus.rsp_instr, hd.instr);
      check_eq("rsp_addr", bus.rsp_addr, hd.addr);
      check_eq("rsp_misalign", 32'(bus.rsp_misalign), 32'(hd.mis));
    end else begin
      check_eq("idle_instr", bus.rsp_instr, Nop);
      check_eq("idle_addr", bus.rsp_addr, 32'h0);
      check_eq("idle_misalign", 32'(bus.rsp_misalign), 32'h0);
    end
    check_eq("mem_en", 32'(mem_en), 32'(exp_en));
    if (exp_en) check_eq("mem_addr", 32'(mem_addr), 32'(a[31:2]));

    @(posedge clk);
    #1;
    if (r || f) begin
      exp_q.delete();
    end else begin
      if (exp_pop) exp_q.delete(0);
      if (exp_accept) begin
        ne.instr = is_aligned(a) ? mem_word(a[31:2]) : Nop;
        ne.addr  = a;
        ne.mis   = !is_aligned(a);
        ne.due   = cyc + 2;
        exp_q.push_back(ne);
      end
    end
    prev_fetch = exp_en;
    prev_waddr = a[31:2];
    cyc++;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, rr);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = $urandom();
    dmem[0] = 32'hA0;
    dmem[1] = 32'hA1;
    dmem[2] = 32'hA2;
    dmem[8] = 32'hDEAD;  // word of 0x20 and 0x22

    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    mem_rdata     = '0;
    @(posedge clk);
    #1;

    // Reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'h0, 1'b1);

    // Streaming
    step(1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h4, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h8, 1'b1);
    idle(4, 1'b1);

    // Backpressure: 0x18 held until a pop frees a slot
    step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h14, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h18, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h18, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h18, 1'b1);
    idle(5, 1'b1);

    // Flush while 0x20's read (0xDEAD) returns
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    idle(4, 1'b1);

    // Misaligned request
    step(1'b0, 1'b0, 1'b1, 32'h22, 1'b1);
    idle(4, 1'b1);

    // Reset with a full FIFO
    step(1'b0, 1'b0, 1'b1, 32'h30, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h34, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h38, 1'b1);
    idle(5, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, f, v, rr;
      logic [31:0] a;
      r  = ($urandom_range(99) == 0);
      f  = ($urandom_range(19) == 0);
      v  = ($urandom_range(3) != 0);
      rr = ($urandom_range(3) != 0);
      a  = {22'h0, 8'($urandom()), 2'b00};
      if ($urandom_range(3) == 0) a[1:0] = 2'($urandom());
      step(r, f, v, a, rr);
    end
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
